// File: rtl/slice_sequencer_param_if.sv
// Patch handshake between the slice sequencer (master) and the bitstream patcher (slave).
// Payload is only meaningful while patch_valid is high; the master zeroes it otherwise.
interface slice_sequencer_param_if #(
  parameter int W = 32
) ();
  logic         patch_valid;
  logic         patch_ready;
  logic [W-1:0] offset_addr;
  logic [W-1:0] val;
  logic [2:0]   byte_size;

  modport master (output patch_valid, offset_addr, val, byte_size, input patch_ready);
  modport slave  (input patch_valid, offset_addr, val, byte_size, output patch_ready);
endinterface

// File: rtl/slice_sequencer_param.sv
// Slice sequencer: header window, per-component encode runs with timeout, then the
// size-patch list (slice/picture/frame/component sizes) streamed over a valid/ready port.
module slice_sequencer_param #(
  parameter int NUM_COMP      = 3,
  parameter int W             = 32,
  parameter int HEADER_CYCLES = 224,
  parameter int COMP_TIMEOUT  = 3000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    comp_done,
  input  logic [W-1:0]            set_bit_total_byte_size,
  input  logic [W-1:0]            slice_size_table_size,
  input  logic [W-1:0]            slice_size_offset_addr,
  input  logic [W-1:0]            picture_size_offset_addr,
  input  logic [W-1:0]            frame_size_offset_addr,
  input  logic [NUM_COMP*W-1:0]   comp_size_offset_addr,
  input  logic [NUM_COMP*W-1:0]   comp_buf_offset,
  input  logic [NUM_COMP*W-1:0]   comp_block_num,
  output logic                    header2_reset_n,
  output logic                    component_reset_n,
  output logic [W-1:0]            offset,
  output logic [W-1:0]            block_num,
  output logic [2:0]              comp_index,
  output logic                    is_y,
  slice_sequencer_param_if.master patch,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);

  localparam int NE  = NUM_COMP + 2;
  localparam int HCW = $clog2(HEADER_CYCLES + 1);
  localparam int RCW = $clog2(COMP_TIMEOUT + 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_COMP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_HDR_GAP, S_COMP_RUN, S_COMP_CAP, S_PATCH, S_FINISH
  } state_t;

  state_t                     r_state, w_next_state;
  logic [HCW-1:0]             r_hdr_cnt;
  logic [RCW-1:0]             r_run_cnt;
  logic [W-1:0]               r_acc;
  logic [NUM_COMP-1:0][W-1:0] r_size;
  logic [2:0]                 r_comp_index;
  logic [W-1:0]               r_offset;
  logic [W-1:0]               r_block_num;
  logic                       r_is_y;
  logic                       r_timeout_err;
  logic [NE-1:0]              r_pending;

  logic                       w_hdr_end, w_run_expire, w_last_comp;
  logic [2:0]                 w_load_idx;
  logic [W-1:0]               w_field_off, w_field_blk;
  logic [NE-1:0][W-1:0]       w_ent_addr, w_ent_val;
  logic [NE-1:0][2:0]         w_ent_bs;
  logic [NE-1:0]              w_live, w_pick;
  logic                       w_valid, w_xfer, w_last_entry;
  logic [W-1:0]               w_pl_addr, w_pl_val;
  logic [2:0]                 w_pl_bs;
  logic                       w_unused_last_addr;

  // The last component's size is never patched, so its address is not consumed.
  assign w_unused_last_addr = ^comp_size_offset_addr[NUM_COMP*W-1 -: W];

  assign w_hdr_end    = (r_hdr_cnt == HCW'(HEADER_CYCLES - 1));
  assign w_run_expire = (r_run_cnt == RCW'(COMP_TIMEOUT - 1));
  assign w_last_comp  = (r_comp_index == LAST_IDX);
  assign w_load_idx   = (r_state == S_HDR_GAP) ? 3'd0 : r_comp_index + 3'd1;

  always_comb begin
    w_field_off = '0;
    w_field_blk = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      if (w_load_idx == 3'(i)) begin
        w_field_off = comp_buf_offset[i*W +: W];
        w_field_blk = comp_block_num[i*W +: W];
      end
    end
  end

  // Patch list in emission order; entries with a zero value are never live.
  always_comb begin
    w_ent_addr    = '0;
    w_ent_val     = '0;
    w_ent_bs      = '0;
    w_ent_addr[0] = slice_size_offset_addr;
    w_ent_val[0]  = r_acc;
    w_ent_bs[0]   = 3'd2;
    w_ent_addr[1] = picture_size_offset_addr;
    w_ent_val[1]  = r_acc + slice_size_table_size - picture_size_offset_addr + W'(1);
    w_ent_bs[1]   = 3'd4;
    w_ent_addr[2] = frame_size_offset_addr;
    w_ent_val[2]  = r_acc + slice_size_table_size;
    w_ent_bs[2]   = 3'd4;
    for (int i = 0; i < NUM_COMP - 1; i++) begin
      w_ent_addr[3+i] = comp_size_offset_addr[i*W +: W];
      w_ent_val[3+i]  = r_size[i];
      w_ent_bs[3+i]   = 3'd2;
    end
  end

  always_comb begin
    w_live = '0;
    for (int k = 0; k < NE; k++) w_live[k] = r_pending[k] && (w_ent_val[k] != '0);
  end

  // Lowest pending non-zero entry is the one on the bus; skipping costs no cycle.
  assign w_pick       = w_live & (~w_live + NE'(1));
  assign w_last_entry = ((w_live & ~w_pick) == '0);
  assign w_valid      = (r_state == S_PATCH) && (w_live != '0);
  assign w_xfer       = w_valid && patch.patch_ready;

  always_comb begin
    w_pl_addr = '0;
    w_pl_val  = '0;
    w_pl_bs   = '0;
    for (int k = 0; k < NE; k++) begin
      if (w_valid && w_pick[k]) begin
        w_pl_addr = w_pl_addr | w_ent_addr[k];
        w_pl_val  = w_pl_val  | w_ent_val[k];
        w_pl_bs   = w_pl_bs   | w_ent_bs[k];
      end
    end
  end

  assign patch.patch_valid = w_valid;
  assign patch.offset_addr = w_pl_addr;
  assign patch.val         = w_pl_val;
  assign patch.byte_size   = w_pl_bs;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next_state = S_HEADER;
      S_HEADER:   if (w_hdr_end) w_next_state = S_HDR_GAP;
      S_HDR_GAP:  w_next_state = S_COMP_RUN;
      S_COMP_RUN: if (comp_done || w_run_expire) w_next_state = S_COMP_CAP;
      S_COMP_CAP: w_next_state = w_last_comp ? S_PATCH : S_COMP_RUN;
      S_PATCH:    if (!w_valid || (w_xfer && w_last_entry)) w_next_state = S_FINISH;
      S_FINISH:   w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr_cnt     <= '0;
      r_run_cnt     <= '0;
      r_acc         <= '0;
      r_size        <= '0;
      r_comp_index  <= '0;
      r_offset      <= '0;
      r_block_num   <= '0;
      r_is_y        <= 1'b1;
      r_timeout_err <= 1'b0;
      r_pending     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hdr_cnt <= '0;
          if (start) r_timeout_err <= 1'b0;
        end
        S_HEADER: r_hdr_cnt <= r_hdr_cnt + 1'b1;
        S_HDR_GAP: begin
          r_acc        <= set_bit_total_byte_size - slice_size_table_size;
          r_comp_index <= '0;
          r_run_cnt    <= '0;
          r_offset     <= w_field_off;
          r_block_num  <= w_field_blk;
          r_is_y       <= 1'b1;
        end
        S_COMP_RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          // A comp_done landing on the expiry cycle is a normal finish.
          if (!comp_done && w_run_expire) r_timeout_err <= 1'b1;
        end
        S_COMP_CAP: begin
          for (int i = 0; i < NUM_COMP; i++)
            if (r_comp_index == 3'(i)) r_size[i] <= set_bit_total_byte_size;
          r_acc <= r_acc + set_bit_total_byte_size;
          if (w_last_comp) begin
            r_pending <= '1;
          end else begin
            r_comp_index <= w_load_idx;
            r_run_cnt    <= '0;
            r_offset     <= w_field_off;
            r_block_num  <= w_field_blk;
            r_is_y       <= (w_load_idx == 3'd0);
          end
        end
        S_PATCH: if (w_xfer) r_pending <= r_pending & ~w_pick;
        S_FINISH: r_pending <= '0;
        default: ;
      endcase
    end
  end

  assign header2_reset_n   = (r_state == S_HEADER);
  assign component_reset_n = (r_state == S_COMP_RUN);
  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_FINISH);
  assign offset            = r_offset;
  assign block_num         = r_block_num;
  assign comp_index        = r_comp_index;
  assign is_y              = r_is_y;
  assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_slice_sequencer_param.sv
// Randomized bench for slice_sequencer_param: a 3-component and a 1-component instance,
// patch stream compared against an entry list computed from the slice byte counts.
module tb_slice_sequencer_param;
  localparam int W  = 32;
  localparam int HC = 224;
  localparam int TO = 3000;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] val;
    logic [2:0]   bs;
  } ent_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset_n, start, comp_done, ready, dsel;
  logic [W-1:0]   sbt, tbl, s_addr, p_addr, f_addr;
  logic [3*W-1:0] c_addr, c_buf, c_blk;

  logic           h2_0, cr_0, isy_0, busy_0, done_0, to_0;
  logic           h2_1, cr_1, isy_1, busy_1, done_1, to_1;
  logic [W-1:0]   off_0, blk_0, off_1, blk_1;
  logic [2:0]     ci_0, ci_1;

  slice_sequencer_param_if #(.W(W)) pif0 ();
  slice_sequencer_param_if #(.W(W)) pif1 ();
  assign pif0.patch_ready = ready;
  assign pif1.patch_ready = ready;

  slice_sequencer_param #(.NUM_COMP(3), .W(W), .HEADER_CYCLES(HC), .COMP_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start & ~dsel), .comp_done(comp_done),
    .set_bit_total_byte_size(sbt), .slice_size_table_size(tbl),
    .slice_size_offset_addr(s_addr), .picture_size_offset_addr(p_addr),
    .frame_size_offset_addr(f_addr), .comp_size_offset_addr(c_addr),
    .comp_buf_offset(c_buf), .comp_block_num(c_blk),
    .header2_reset_n(h2_0), .component_reset_n(cr_0), .offset(off_0), .block_num(blk_0),
    .comp_index(ci_0), .is_y(isy_0), .patch(pif0), .busy(busy_0), .done(done_0),
    .timeout_err(to_0)
  );

  slice_sequencer_param #(.NUM_COMP(1), .W(W), .HEADER_CYCLES(HC), .COMP_TIMEOUT(TO)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start & dsel), .comp_done(comp_done),
    .set_bit_total_byte_size(sbt), .slice_size_table_size(tbl),
    .slice_size_offset_addr(s_addr), .picture_size_offset_addr(p_addr),
    .frame_size_offset_addr(f_addr), .comp_size_offset_addr(c_addr[W-1:0]),
    .comp_buf_offset(c_buf[W-1:0]), .comp_block_num(c_blk[W-1:0]),
    .header2_reset_n(h2_1), .component_reset_n(cr_1), .offset(off_1), .block_num(blk_1),
    .comp_index(ci_1), .is_y(isy_1), .patch(pif1), .busy(busy_1), .done(done_1),
    .timeout_err(to_1)
  );

  // Observed view of whichever instance is under test.
  logic         h2, cr, isy, busy, done, tout, pv;
  logic [W-1:0] off, blk, paddr, pval;
  logic [2:0]   ci, pbs;
  assign h2    = dsel ? h2_1   : h2_0;
  assign cr    = dsel ? cr_1   : cr_0;
  assign isy   = dsel ? isy_1  : isy_0;
  assign busy  = dsel ? busy_1 : busy_0;
  assign done  = dsel ? done_1 : done_0;
  assign tout  = dsel ? to_1   : to_0;
  assign off   = dsel ? off_1  : off_0;
  assign blk   = dsel ? blk_1  : blk_0;
  assign ci    = dsel ? ci_1   : ci_0;
  assign pv    = dsel ? pif1.patch_valid : pif0.patch_valid;
  assign paddr = dsel ? pif1.offset_addr : pif0.offset_addr;
  assign pval  = dsel ? pif1.val         : pif0.val;
  assign pbs   = dsel ? pif1.byte_size   : pif0.byte_size;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference model: slice byte counts -> ordered patch list with zero values dropped.
  logic [W-1:0] hdr_cnt;
  logic [W-1:0] bc [3];
  ent_t         expq [$];

  function automatic void add_ent(input logic [W-1:0] a, input logic [W-1:0] v, input logic [2:0] b);
    ent_t e;
    if (v != '0) begin
      e.addr = a; e.val = v; e.bs = b;
      expq.push_back(e);
    end
  endfunction

  function automatic logic [W-1:0] slice_total(input int nc);
    logic [W-1:0] a;
    a = hdr_cnt - tbl;
    for (int i = 0; i < nc; i++) a = a + bc[i];
    return a;
  endfunction

  function automatic void build_model(input int nc);
    logic [W-1:0] a;
    a = slice_total(nc);
    expq.delete();
    add_ent(s_addr, a, 3'd2);
    add_ent(p_addr, a + tbl - p_addr + 1, 3'd4);
    add_ent(f_addr, a + tbl, 3'd4);
    for (int i = 0; i < nc - 1; i++) add_ent(c_addr[i*W +: W], bc[i], 3'd2);
  endfunction

  task automatic rand_cfg();
    tbl     = $urandom_range(0, 4095);
    hdr_cnt = $urandom;
    for (int i = 0; i < 3; i++) bc[i] = $urandom;
    s_addr  = $urandom; p_addr = $urandom; f_addr = $urandom;
    c_addr  = {$urandom, $urandom, $urandom};
    c_buf   = {$urandom, $urandom, $urandom};
    c_blk   = {$urandom, $urandom, $urandom};
  endtask

  // to_mask: components left to time out; edge_mask: comp_done on the expiry cycle.
  // rmode 0: ready always high, 1: random ready, 2: ready low for the first 5 valid cycles.
  task automatic run_slice(input int nc, input int to_mask, input int edge_mask, input int rmode,
                           input bit poke, input bit abort);
    int n, d, gap, stall;
    bit exp_to;
    build_model(nc);
    exp_to = 1'b0;
    @(negedge clock);
    chk("idle_busy", busy, 0);
    sbt   = hdr_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_clears_to", tout, 0);
    chk("hdr_busy", busy, 1);
    n = 0;
    while (h2 && n < HC + 10) begin n++; @(negedge clock); end
    chk("hdr_len", n, HC);
    for (int i = 0; i < nc; i++) begin
      n = 0;
      while (!cr && n < 8) begin n++; @(negedge clock); end
      chk("run_entry", cr, 1);
      chk("comp_index", ci, i);
      chk("offset", off, c_buf[i*W +: W]);
      chk("block_num", blk, c_blk[i*W +: W]);
      chk("is_y", isy, (i == 0));
      if (to_mask[i]) begin
        sbt = bc[i];
        n = 0;
        while (cr && n < TO + 10) begin n++; @(negedge clock); end
        chk("timeout_len", n, TO);
        chk("timeout_flag", tout, 1);
        exp_to = 1'b1;
      end else begin
        if (poke) begin
          start = 1'b1;
          @(negedge clock);
          start = 1'b0;
          chk("poke_ignored_h2", h2, 0);
          chk("poke_ignored_cr", cr, 1);
        end
        d = edge_mask[i] ? TO - 1 : $urandom_range(0, 20);
        repeat (d) @(negedge clock);
        chk("run_hold", cr, 1);
        sbt       = bc[i];
        comp_done = 1'b1;
        @(negedge clock);
        comp_done = 1'b0;
        chk("cap_reset", cr, 0);
        chk("cap_to_flag", tout, exp_to);
      end
    end
    @(negedge clock);
    n = 0; gap = 0; stall = 0;
    while (!done && n < 300) begin
      if (pv) begin
        if (expq.size() == 0) chk("extra_entry", pval, 0);
        else begin
          chk("patch_addr", paddr, expq[0].addr);
          chk("patch_val", pval, expq[0].val);
          chk("patch_bs", pbs, expq[0].bs);
        end
      end else begin
        gap++;
        chk("idle_payload", paddr | pval | W'(pbs), 0);
      end
      if (abort && n == 3) begin
        chk("pre_abort_valid", pv, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_pv", pv, 0);
        chk("rst_payload", paddr | pval | W'(pbs), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_to", tout, 0);
        chk("rst_h2", h2, 0);
        chk("rst_cr", cr, 0);
        chk("rst_ci", ci, 0);
        chk("rst_off", off | blk, 0);
        chk("rst_isy", isy, 1);
        expq.delete();
        ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
          @(negedge clock);
          chk("post_rst_pv", pv, 0);
          chk("post_rst_busy", busy, 0);
        end
        return;
      end
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: begin ready = (stall >= 5); if (pv) stall++; end
      endcase
      if (pv && ready && expq.size() > 0) void'(expq.pop_front());
      n++;
      @(negedge clock);
    end
    ready = 1'b0;
    chk("done_seen", done, 1);
    chk("entries_left", expq.size(), 0);
    chk("final_to", tout, exp_to);
    if (rmode == 0) chk("b2b_gap", gap, 0);
    @(negedge clock);
    chk("done_pulse", done, 0);
    chk("back_idle", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; start = 1'b0; comp_done = 1'b0; ready = 1'b0; dsel = 1'b0;
    sbt = '0; tbl = '0; s_addr = '0; p_addr = '0; f_addr = '0;
    c_addr = '0; c_buf = '0; c_blk = '0; hdr_cnt = '0;
    for (int i = 0; i < 3; i++) bc[i] = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_h2", h2, 0);
    chk("reset_cr", cr, 0);
    chk("reset_isy", isy, 1);
    chk("reset_pv", pv, 0);
    chk("reset_to", tout, 0);
    chk("reset_ci", ci, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reference slice: 116-16=100, +516+716+916, back-to-back patches.
    tbl = 16; hdr_cnt = 116; bc[0] = 516; bc[1] = 716; bc[2] = 916;
    s_addr = 32'h100; p_addr = 32'h40; f_addr = 32'h20;
    c_addr = {32'h300, 32'h208, 32'h200};
    c_buf  = {32'h3000, 32'h2000, 32'h1000};
    c_blk  = {32'd16, 32'd16, 32'd32};
    run_slice(3, 0, 0, 0, 1'b0, 1'b0);

    rand_cfg(); run_slice(3, 0, 0, 2, 1'b0, 1'b0);    // stalled first entry
    rand_cfg(); run_slice(3, 2, 0, 1, 1'b0, 1'b0);    // component 1 times out
    rand_cfg(); bc[0] = '0;
    run_slice(3, 0, 4, 0, 1'b0, 1'b0);                // size0 skipped, done on expiry cycle
    for (int k = 0; k < 4; k++) begin
      rand_cfg();
      if (k == 1) p_addr = slice_total(3) + tbl + 1;  // picture value wraps to zero
      run_slice(3, 0, 0, 1, 1'b0, 1'b0);
    end
    rand_cfg(); run_slice(3, 4, 0, 2, 1'b0, 1'b1);    // reset while stalled in PATCH
    rand_cfg(); run_slice(3, 0, 0, 1, 1'b0, 1'b0);

    dsel = 1'b1;
    repeat (2) @(negedge clock);
    rand_cfg(); run_slice(1, 0, 0, 1, 1'b1, 1'b0);    // single component, start during run
    rand_cfg(); run_slice(1, 1, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
